dma_arbiter: RTL and testbench

Round-robin arbiter that shares the single fully-connected-layer DMA engine between NUM_REQ requesters, e.g. the weight loader and the input-vector loader. It latches the winning requester's address and count, drives the DMA read handshake, waits for DMA ready, and returns a one-cycle completion pulse to the owner. While granted, the owner has exclusive use of the DMA buffer.

---
 rtl/dma_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dma_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_arbiter.sv
// dma_arbiter
//   Round-robin arbiter sharing one DMA read engine between NUM_REQ
//   requesters. The winner's start address and word count are latched,
//   the DMA read handshake is driven until ready, and a one-cycle
//   completion pulse is returned to the owner. The owner keeps its grant
//   (and exclusive use of the DMA buffer) until the DMA drops ready.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   i_req           : level request per requester
//   i_address       : packed start addresses, requester k at [k*W +: W]
//   i_count         : packed word counts, same packing
//   o_grant         : one-hot current owner, zero when idle
//   o_done          : one-cycle completion pulse to the owner
//   o_busy          : arbiter is not idle
//   o_dma_read      : DMA read request
//   o_dma_address   : latched start address to the DMA
//   o_dma_count     : latched word count to the DMA
//   i_dma_ready     : DMA buffer holds the requested words
module dma_arbiter #(
    parameter int unsigned NUM_REQ           = 2,
    parameter int unsigned MEM_ADDRESS_WIDTH = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   i_req,
    input  logic [NUM_REQ*MEM_ADDRESS_WIDTH-1:0] i_address,
    input  logic [NUM_REQ*MEM_ADDRESS_WIDTH-1:0] i_count,
    output logic [NUM_REQ-1:0]                   o_grant,
    output logic [NUM_REQ-1:0]                   o_done,
    output logic                                 o_busy,
    output logic                                 o_dma_read,
    output logic [MEM_ADDRESS_WIDTH-1:0]         o_dma_address,
    output logic [MEM_ADDRESS_WIDTH-1:0]         o_dma_count,
    input  logic                                 i_dma_ready
);

    localparam int unsigned W     = MEM_ADDRESS_WIDTH;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   last, last_n;
    logic [NUM_REQ-1:0] grant_n, done_n;
    logic               busy_n, read_n;
    logic [W-1:0]       addr_n, count_n;

    // Arbitration result
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [W-1:0]       sel_addr, sel_count;

    // Search last+1, last+2, ... (mod NUM_REQ); the first set request wins.
    // Offset NUM_REQ wraps back to `last`, so a lone requester that won
    // last time is still served.
    always_comb begin
        found = 1'b0;
        pick  = last;
        cand  = last;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((32'(last) + off) % NUM_REQ);
            if (!found && i_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        sel_onehot       = '0;
        sel_onehot[pick] = 1'b1;
        sel_addr         = '0;
        sel_count        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick == IDX_W'(k)) begin
                sel_addr  = i_address[k*W +: W];
                sel_count = i_count[k*W +: W];
            end
        end
    end

    // Next-state and next-output logic; every output is then registered.
    always_comb begin
        state_n = state;
        last_n  = last;
        grant_n = o_grant;
        done_n  = '0;
        read_n  = o_dma_read;
        addr_n  = o_dma_address;
        count_n = o_dma_count;

        unique case (state)
            IDLE: begin
                if (found) begin
                    last_n  = pick;
                    grant_n = sel_onehot;
                    addr_n  = sel_addr;
                    count_n = sel_count;
                    if (sel_count != '0) begin
                        state_n = XFER;
                        read_n  = 1'b1;
                    end else begin
                        // Nothing to fetch: complete immediately, but the
                        // owner still passes through DRAIN so IDLE cannot
                        // re-grant it before it drops its request.
                        state_n = DRAIN;
                        done_n  = sel_onehot;
                    end
                end
            end
            XFER: begin
                if (i_dma_ready) begin
                    read_n  = 1'b0;
                    done_n  = o_grant;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (!i_dma_ready) begin
                    grant_n = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                read_n  = 1'b0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last          <= IDX_W'(NUM_REQ - 1);
            o_grant       <= '0;
            o_done        <= '0;
            o_busy        <= 1'b0;
            o_dma_read    <= 1'b0;
            o_dma_address <= '0;
            o_dma_count   <= '0;
        end else begin
            state         <= state_n;
            last          <= last_n;
            o_grant       <= grant_n;
            o_done        <= done_n;
            o_busy        <= busy_n;
            o_dma_read    <= read_n;
            o_dma_address <= addr_n;
            o_dma_count   <= count_n;
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter
//   Self-checking bench for dma_arbiter with two requesters and a small
//   DMA model backed by an 8-word memory holding 0..7. Each request
//   pushes its expected owner/address/count to a scoreboard queue; grants
//   are matched against the queue head and completions pop it.
module tb_dma_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned W  = 3;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     i_req;
    logic [NR*W-1:0]   i_address;
    logic [NR*W-1:0]   i_count;
    logic [NR-1:0]     o_grant;
    logic [NR-1:0]     o_done;
    logic              o_busy;
    logic              o_dma_read;
    logic [W-1:0]      o_dma_address;
    logic [W-1:0]      o_dma_count;
    logic              i_dma_ready;

    dma_arbiter #(
        .NUM_REQ          (NR),
        .MEM_ADDRESS_WIDTH(W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_address    (i_address),
        .i_count      (i_count),
        .o_grant      (o_grant),
        .o_done       (o_done),
        .o_busy       (o_busy),
        .o_dma_read   (o_dma_read),
        .o_dma_address(o_dma_address),
        .o_dma_count  (o_dma_count),
        .i_dma_ready  (i_dma_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_done   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] oh(input int unsigned k);
        logic [NR-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Scoreboard
    typedef struct {
        int unsigned owner;
        logic [W-1:0] addr;
        logic [W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    function automatic void push_req(input int unsigned k);
        exp_t e;
        e.owner = k;
        e.addr  = i_address[k*W +: W];
        e.cnt   = i_count[k*W +: W];
        exp_q.push_back(e);
    endfunction

    // DMA model: raises ready dma_lat cycles after read, filling the
    // buffer; drops ready dma_hold cycles after read falls.
    logic [W-1:0] mem [8];
    logic [W-1:0] dma_buf [8];
    int unsigned  dma_lat  = 2;
    int unsigned  dma_hold = 0;

    initial begin
        int unsigned lat_cnt;
        int unsigned hold_cnt;
        for (int i = 0; i < 8; i++) begin
            mem[i]     = W'(i);
            dma_buf[i] = '0;
        end
        i_dma_ready = 1'b0;
        lat_cnt     = 0;
        hold_cnt    = 0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                i_dma_ready = 1'b0;
                lat_cnt     = 0;
                hold_cnt    = 0;
            end else if (o_dma_read && !i_dma_ready) begin
                lat_cnt++;
                if (lat_cnt >= dma_lat) begin
                    for (int i = 0; i < int'(o_dma_count); i++)
                        dma_buf[i] = mem[(int'(o_dma_address) + i) % 8];
                    i_dma_ready = 1'b1;
                    lat_cnt     = 0;
                    hold_cnt    = 0;
                end
            end else if (i_dma_ready && !o_dma_read) begin
                if (hold_cnt >= dma_hold) i_dma_ready = 1'b0;
                else                      hold_cnt++;
            end
        end
    end

    // Monitor: invariants every cycle, grant order at grant rise,
    // completion contents at o_done.
    logic [NR-1:0] mon_prev_grant = '0;
    exp_t          mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            check_value("grant_onehot", 32'($countones(o_grant) <= 1), 1);
            check_value("done_read_excl", 32'((|o_done) & o_dma_read), 0);
            if (o_grant != '0 && mon_prev_grant == '0) begin
                if (exp_q.size() == 0) check_value("grant_unexpected", o_grant, 0);
                else                   check_value("grant_order", o_grant, oh(exp_q[0].owner));
            end
            if (o_done != '0) begin
                if (exp_q.size() == 0) begin
                    check_value("done_unexpected", o_done, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_done++;
                    check_value("done_owner", o_done, oh(mon_e.owner));
                    check_value("done_grant", o_grant, oh(mon_e.owner));
                    for (int i = 0; i < int'(mon_e.cnt); i++)
                        check_value("buf_word", dma_buf[i], (int'(mon_e.addr) + i) % 8);
                end
            end
        end
        mon_prev_grant = o_grant;
    end

    // Requester behaviour: drop on the edge sampling done; optionally
    // re-raise one cycle later (rearms times per requester).
    task automatic serve(input int unsigned rearms, input int unsigned budget);
        logic [NR-1:0] d;
        logic [NR-1:0] rn;
        int unsigned   left[NR];
        bit            fin;
        rn  = '0;
        fin = 1'b0;
        for (int k = 0; k < NR; k++) left[k] = rearms;
        for (int unsigned c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            d = o_done;
            @(posedge clk);
            #1;
            i_req = i_req & ~d;
            for (int k = 0; k < NR; k++) begin
                if (rn[k]) begin
                    i_req[k] = 1'b1;
                    push_req(k);
                end
            end
            for (int k = 0; k < NR; k++) begin
                rn[k] = d[k] && (left[k] > 0);
                if (rn[k]) left[k]--;
            end
            fin = (exp_q.size() == 0) && (i_req == '0) && (rn == '0) && !o_busy;
        end
        check_value("serve_complete", 32'(fin), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_grant"}, o_grant, 0);
        check_value({tag, "_done"}, o_done, 0);
        check_value({tag, "_busy"}, 32'(o_busy), 0);
        check_value({tag, "_read"}, 32'(o_dma_read), 0);
        check_value({tag, "_addr"}, o_dma_address, 0);
        check_value({tag, "_count"}, o_dma_count, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        i_req = '0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] d;
        logic [NR-1:0] held;
        logic [NR-1:0] pg;
        int unsigned   done1_cycles;
        int unsigned   base;
        bit            fin;

        reset     = 1'b1;
        i_req     = '0;
        i_address = '0;
        i_count   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single request: req0, address 1, count 4
        dma_lat  = 2;
        dma_hold = 0;
        @(posedge clk);
        #1;
        i_address[0 +: W] = 3'd1;
        i_count[0 +: W]   = 3'd4;
        i_req[0]          = 1'b1;
        push_req(0);
        @(negedge clk);
        check_value("t1_idle_grant", o_grant, 0);
        @(negedge clk);
        check_value("t1_grant", o_grant, 2'b01);
        check_value("t1_read", 32'(o_dma_read), 1);
        check_value("t1_busy", 32'(o_busy), 1);
        check_value("t1_addr", o_dma_address, 1);
        check_value("t1_count", o_dma_count, 4);
        serve(0, 40);

        // Simultaneous requests after requester 0 won: rotation picks 1
        @(posedge clk);
        #1;
        i_address[0 +: W] = 3'd0;
        i_count[0 +: W]   = 3'd3;
        i_address[W +: W] = 3'd5;
        i_count[W +: W]   = 3'd2;
        i_req             = 2'b11;
        push_req(1);
        push_req(0);
        serve(0, 60);

        // Fairness from reset: expected order 0,1,0,1
        apply_reset();
        base  = n_done;
        i_req = 2'b11;
        push_req(0);
        push_req(1);
        serve(1, 150);
        check_value("fair_grants", n_done - base, 4);

        // Latch check: inputs change and req1 drops during XFER
        dma_lat = 4;
        @(posedge clk);
        #1;
        i_address[W +: W] = 3'd2;
        i_count[W +: W]   = 3'd3;
        i_req[1]          = 1'b1;
        push_req(1);
        @(negedge clk);
        @(negedge clk);
        check_value("latch_grant", o_grant, 2'b10);
        check_value("latch_read", 32'(o_dma_read), 1);
        check_value("latch_addr", o_dma_address, 2);
        check_value("latch_count", o_dma_count, 3);
        @(posedge clk);
        #1;
        i_address[W +: W] = 3'd6;
        i_count[W +: W]   = 3'd1;
        i_req[1]          = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_value("latch_hold_read", 32'(o_dma_read), 1);
            check_value("latch_hold_addr", o_dma_address, 2);
            check_value("latch_hold_count", o_dma_count, 3);
        end
        serve(0, 40);

        // Zero count on requester 0
        @(posedge clk);
        #1;
        i_address[0 +: W] = 3'd3;
        i_count[0 +: W]   = 3'd0;
        i_req[0]          = 1'b1;
        push_req(0);
        @(negedge clk);
        check_value("zero_idle_busy", 32'(o_busy), 0);
        @(negedge clk);
        check_value("zero_grant", o_grant, 2'b01);
        check_value("zero_done", o_done, 2'b01);
        check_value("zero_read", 32'(o_dma_read), 0);
        check_value("zero_busy", 32'(o_busy), 1);
        @(posedge clk);
        #1;
        i_req[0] = 1'b0;
        @(negedge clk);
        check_value("zero_back_idle", 32'(o_busy), 0);
        check_value("zero_grant_clr", o_grant, 0);
        check_value("zero_read_after", 32'(o_dma_read), 0);
        check_value("zero_done_once", o_done, 0);

        // Reset in the middle of a transfer
        dma_lat = 10;
        @(posedge clk);
        #1;
        i_address[0 +: W] = 3'd1;
        i_count[0 +: W]   = 3'd4;
        i_req[0]          = 1'b1;
        push_req(0);
        @(negedge clk);
        @(negedge clk);
        check_value("midrst_read", 32'(o_dma_read), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("midrst");
        exp_q.delete();
        dma_lat = 1;
        @(posedge clk);
        #1;
        reset             = 1'b0;
        i_address[W +: W] = 3'd6;
        i_count[W +: W]   = 3'd2;
        i_req             = 2'b11;
        push_req(0);
        push_req(1);
        serve(0, 60);

        // Slow ready release: ready held 3 cycles after read drops
        dma_lat  = 1;
        dma_hold = 3;
        @(posedge clk);
        #1;
        i_address[W +: W] = 3'd4;
        i_count[W +: W]   = 3'd2;
        i_address[0 +: W] = 3'd0;
        i_count[0 +: W]   = 3'd1;
        i_req[1]          = 1'b1;
        push_req(1);
        held         = '0;
        pg           = '0;
        done1_cycles = 0;
        fin          = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            d = o_done;
            if (o_grant != '0 && pg == '0) held = o_grant;
            if (i_dma_ready && !o_dma_read) begin
                check_value("slow_grant_held", o_grant, held);
                check_value("slow_busy_held", 32'(o_busy), 1);
            end
            if (d[1]) done1_cycles++;
            pg = o_grant;
            @(posedge clk);
            #1;
            i_req = i_req & ~d;
            if (c == 1) begin
                i_req[0] = 1'b1;
                push_req(0);
            end
            fin = (c > 1) && (exp_q.size() == 0) && (i_req == '0) && !o_busy;
        end
        check_value("slow_done_len", done1_cycles, 1);
        check_value("slow_complete", 32'(fin), 1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
